// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: sends one byte per accepted request on an idle-high line.
// Requests that arrive while a frame is in flight are dropped; there is no buffering.
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter bit          EDGE_START   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] byte_to_send,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          start_prev;
  logic          tx_d, busy_d, done_d;
  logic          req;
  logic          bit_end;

  // Edge mode only fires on a low-to-high transition seen by start_prev.
  assign req     = EDGE_START ? (tx_start & ~start_prev) : tx_start;
  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx;
    busy_d  = tx_busy;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (req) begin
          shreg_d = byte_to_send;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          tx_d    = shreg_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            // Shift so the next bit to send always sits at shreg_q[0].
            idx_d   = idx_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      shreg_q    <= 8'd0;
      start_prev <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      start_prev <= tx_start;
      tx         <= tx_d;
      tx_busy    <= busy_d;
      tx_done    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: one edge-mode and one level-mode instance,
// frames decoded by mid-bit sampling and compared against an 8N1 frame model.
module tb_uart_tx_serializer;

  localparam int unsigned CPB = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_e, start_l;
  logic [7:0] byte_e, byte_l;
  logic       tx_e, busy_e, done_e;
  logic       tx_l, busy_l, done_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .EDGE_START(1'b1)) dut_e (
    .clk(clk), .rst(rst), .tx_start(start_e), .byte_to_send(byte_e),
    .tx(tx_e), .tx_busy(busy_e), .tx_done(done_e)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .EDGE_START(1'b0)) dut_l (
    .clk(clk), .rst(rst), .tx_start(start_l), .byte_to_send(byte_l),
    .tx(tx_l), .tx_busy(busy_l), .tx_done(done_l)
  );

  // Line image of an 8N1 frame, bit 0 first on the wire.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Records one frame window after the accept edge (request set before the call).
  // act 1: change byte at act_cyc; act 2: one-cycle start pulse with act_byte at act_cyc.
  task automatic capture(input bit sel, input bit drop_start, input int act, input int act_cyc,
                         input logic [7:0] act_byte, output logic [9:0] bits,
                         output int busy_cnt, output int done_cnt, output int done_pos,
                         output logic first_tx, output logic first_busy);
    logic t, b, d;
    bits = '0; busy_cnt = 0; done_cnt = 0; done_pos = -1; first_tx = 1'bx; first_busy = 1'bx;
    for (int c = 0; c <= int'(FRAME); c++) begin
      @(negedge clk);
      t = sel ? tx_l : tx_e;
      b = sel ? busy_l : busy_e;
      d = sel ? done_l : done_e;
      if (c == 0) begin first_tx = t; first_busy = b; end
      if ((c % CPB) == CPB / 2 && c < int'(FRAME)) bits[c / CPB] = t;
      if (b === 1'b1) busy_cnt++;
      if (d === 1'b1) begin
        done_cnt++;
        if (done_pos < 0) done_pos = c;
      end
      if (c == 0 && drop_start) begin
        if (sel) start_l = 1'b0; else start_e = 1'b0;
      end
      if (act == 1 && c == act_cyc) begin
        if (sel) byte_l = act_byte; else byte_e = act_byte;
      end
      if (act == 2 && c == act_cyc) begin
        if (sel) begin start_l = 1'b1; byte_l = act_byte; end
        else begin start_e = 1'b1; byte_e = act_byte; end
      end
      if (act == 2 && c == act_cyc + 1) begin
        if (sel) start_l = 1'b0; else start_e = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({tx_e, busy_e, done_e, tx_l, busy_l, done_l} !== 6'b100100) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=100100", i,
                 {tx_e, busy_e, done_e, tx_l, busy_l, done_l});
      end
      start_e = 1'($urandom); byte_e = 8'($urandom);
      start_l = 1'($urandom); byte_l = 8'($urandom);
    end
    start_e = 1'b0; start_l = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({tx_e, busy_e, done_e, tx_l, busy_l, done_l} !== 6'b100100) begin
        errors++;
        $display("FAIL reset_release cyc=%0d got=%b exp=100100", i,
                 {tx_e, busy_e, done_e, tx_l, busy_l, done_l});
      end
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] b, input logic [9:0] bits,
                             input int busy_cnt, input int done_cnt, input int done_pos,
                             input logic first_tx, input logic first_busy);
    checks++;
    if (bits !== frame_of(b)) begin
      errors++;
      $display("FAIL %s_bits got=%b exp=%b", name, bits, frame_of(b));
    end
    checks++;
    if ({first_tx, first_busy} !== 2'b01) begin
      errors++;
      $display("FAIL %s_accept tx/busy got=%b exp=01", name, {first_tx, first_busy});
    end
    checks++;
    if (busy_cnt != int'(FRAME)) begin
      errors++;
      $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, busy_cnt, FRAME);
    end
    checks++;
    if (done_cnt != 1 || done_pos != int'(FRAME)) begin
      errors++;
      $display("FAIL %s_done got count=%0d pos=%0d exp count=1 pos=%0d", name, done_cnt,
               done_pos, FRAME);
    end
  endtask

  task automatic test_single_a5();
    logic [9:0] bits; int bc, dc, dp; logic ft, fb;
    start_e = 1'b1; byte_e = 8'hA5;
    capture(1'b0, 1'b1, 0, 0, 8'h00, bits, bc, dc, dp, ft, fb);
    check_frame("a5", 8'hA5, bits, bc, dc, dp, ft, fb);
    @(negedge clk);
    checks++;
    if ({tx_e, busy_e, done_e} !== 3'b100) begin
      errors++;
      $display("FAIL a5_after_done got=%b exp=100", {tx_e, busy_e, done_e});
    end
  endtask

  task automatic test_held_edge();
    logic [9:0] bits; int bc, dc, dp; logic ft, fb; int bad;
    start_e = 1'b1; byte_e = 8'h3C;
    capture(1'b0, 1'b0, 0, 0, 8'h00, bits, bc, dc, dp, ft, fb);
    check_frame("held", 8'h3C, bits, bc, dc, dp, ft, fb);
    bad = 0;
    for (int i = 0; i < 200 - int'(FRAME) - 1; i++) begin
      @(negedge clk);
      if ({tx_e, busy_e, done_e} !== 3'b100) bad++;
    end
    start_e = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL held_no_retrigger bad_cycles got=%0d exp=0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] bits; int bc, dc, dp; logic ft, fb; int bad;
    start_l = 1'b1; byte_l = 8'h01;
    capture(1'b1, 1'b0, 1, 20, 8'h80, bits, bc, dc, dp, ft, fb);
    check_frame("b2b_first", 8'h01, bits, bc, dc, dp, ft, fb);
    // Second window starts one cycle after the done cycle: 41-cycle period.
    capture(1'b1, 1'b1, 0, 0, 8'h00, bits, bc, dc, dp, ft, fb);
    check_frame("b2b_second", 8'h80, bits, bc, dc, dp, ft, fb);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ({tx_l, busy_l, done_l} !== 3'b100) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_idle_after bad_cycles got=%0d exp=0", bad);
    end
  endtask

  task automatic test_busy_ignored();
    logic [9:0] bits; int bc, dc, dp; logic ft, fb; int bad;
    start_e = 1'b1; byte_e = 8'h55;
    capture(1'b0, 1'b1, 2, 15, 8'hFF, bits, bc, dc, dp, ft, fb);
    check_frame("busy_ign", 8'h55, bits, bc, dc, dp, ft, fb);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ({tx_e, busy_e, done_e} !== 3'b100) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL busy_ign_no_second bad_cycles got=%0d exp=0", bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits; int bc, dc, dp; logic ft, fb; int bad;
    start_e = 1'b1; byte_e = 8'hC3;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 0) start_e = 1'b0;
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({tx_e, busy_e, done_e} !== 3'b100) begin
      errors++;
      $display("FAIL midreset_immediate got=%b exp=100", {tx_e, busy_e, done_e});
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({tx_e, busy_e, done_e} !== 3'b100) bad++;
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if ({tx_e, busy_e, done_e} !== 3'b100) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midreset_quiet bad_cycles got=%0d exp=0", bad);
    end
    start_e = 1'b1; byte_e = 8'h0F;
    capture(1'b0, 1'b1, 0, 0, 8'h00, bits, bc, dc, dp, ft, fb);
    check_frame("midreset_next", 8'h0F, bits, bc, dc, dp, ft, fb);
  endtask

  task automatic test_random_frames();
    logic [9:0] bits; int bc, dc, dp; logic ft, fb; logic [7:0] b;
    for (int n = 0; n < 8; n++) begin
      int gap;
      gap = int'($urandom_range(0, 5));
      for (int i = 0; i < gap; i++) begin
        @(negedge clk);
        byte_e = 8'($urandom);
      end
      b = 8'($urandom);
      start_e = 1'b1; byte_e = b;
      capture(1'b0, 1'b1, 1, int'($urandom_range(1, 30)), 8'($urandom), bits, bc, dc, dp,
              ft, fb);
      check_frame("random", b, bits, bc, dc, dp, ft, fb);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_e = 1'b0; start_l = 1'b0; byte_e = 8'h00; byte_l = 8'h00;
    test_reset();
    test_single_a5();
    test_held_edge();
    test_back_to_back();
    test_busy_ignored();
    test_reset_mid_frame();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

8N1 UART transmitter that serializes one byte per request onto a single idle-high serial line. It sits downstream of the debug byte-generation logic: it consumes the `byte_to_send` / `tx_start` pair and drives the board TX pin. It reports `tx_busy` and a one-cycle `tx_done` back to the requester. There is no input buffering: a request that arrives while a frame is in flight is dropped.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868 (100 MHz / 115200 baud): clock cycles per serial bit. Legal values are 2 and above.
- `EDGE_START`, default 1:
  - 1: a frame starts only on a rising edge of `tx_start`, so a held button sends exactly one frame.
  - 0: a frame starts whenever `tx_start` is high while idle.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: system clock, all logic on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `tx_start` input 1: transmit request, level or edge per `EDGE_START`.
- `byte_to_send` input 8: payload, sampled only on the accept edge.
- `tx` output 1: serial line, idle high, registered.
- `tx_busy` output 1: high from the accept edge until the frame completes.
- `tx_done` output 1: one-cycle pulse at the end of each completed frame.

## Operation
- States: IDLE, START, DATA, STOP.
- Registers:
  - bit counter, width $clog2(CLKS_PER_BIT), counting 0..CLKS_PER_BIT-1.
  - 3-bit data index.
  - 8-bit shift/latch register.
  - `start_prev`, reset 0.
- Request qualification:
  - `req = tx_start & ~start_prev` when `EDGE_START`=1; otherwise `req = tx_start`.
  - `start_prev <= tx_start` every cycle, in all states.
- IDLE with `req` high (accept edge):
  - latch `byte_to_send`.
  - `tx<=0`, `tx_busy<=1`, counter `<=0`, go to START.
- IDLE without `req`: `tx=1`, `tx_busy=0`.
- Bit timing: every bit (start, 8 data bits, stop) is held for exactly CLKS_PER_BIT cycles. When counter == CLKS_PER_BIT-1, clear the counter and advance.
- START → DATA: drive data bit 0; data is sent LSB first.
- DATA: after bit index 7 completes, go to STOP and drive `tx=1`.
- STOP complete:
  - go to IDLE.
  - `tx_busy<=0`, `tx_done<=1` for exactly one cycle.
- `tx_start` and `byte_to_send` are ignored outside IDLE. There is no queueing, and the latched byte is not updated mid-frame.
- With `EDGE_START`=1, a rising edge that occurs while busy is consumed by `start_prev` and produces no frame.
- Reset, including mid-frame:
  - `tx=1`, `tx_busy=0`, `tx_done=0`, state IDLE, counters 0, `start_prev=0`. The frame in flight is abandoned.
  - A `tx_start` held high through reset release counts as a rising edge on the first post-reset cycle.

## Timing
- Reset values: `tx=1`, `tx_busy=0`, `tx_done=0`.
- Accept edge = E0:
  - `tx` falls to 0 and `tx_busy` rises, both visible right after E0.
- Data bit k occupies cycles E0+(k+1)·CLKS_PER_BIT to E0+(k+2)·CLKS_PER_BIT-1.
- Stop bit occupies E0+9·CLKS_PER_BIT to E0+10·CLKS_PER_BIT-1.
- At edge E0+10·CLKS_PER_BIT:
  - `tx_busy` falls and `tx_done` rises for 1 cycle.
  - `tx_busy` was therefore high for exactly 10·CLKS_PER_BIT cycles.
- The earliest next accept is the `tx_done` cycle (IDLE), giving:
  - frame period 10·CLKS_PER_BIT+1 cycles;
  - an effective stop/idle high time of CLKS_PER_BIT+1 cycles.
- Latency from `req` to the start-bit edge is 0 cycles; the edge is registered on the accept clock.

## Test plan
All scenarios use CLKS_PER_BIT=4.
1. Reset asserted with random inputs → `tx=1`, `tx_busy=0`, `tx_done=0`. After release with `tx_start=0`, the outputs stay the same.
2. One-cycle `tx_start` with `byte_to_send`=0xA5 → sampling mid-bit gives the sequence 0,1,0,1,0,0,1,0,1,1. `tx_busy` is high for 40 cycles, and a single `tx_done` pulse occurs at E0+40.
3. `EDGE_START`=1, `tx_start` held for 200 cycles with 0x3C → exactly one frame (0x3C, LSB first) and one `tx_done`. `tx` stays idle afterward.
4. `EDGE_START`=0, `tx_start` held continuously:
   - `byte_to_send` changes from 0x01 to 0x80 mid-frame.
   - Required: back-to-back frames with a 41-cycle period; the first carries 0x01 and the second 0x80.
5. While busy sending 0x55, pulse `tx_start` with 0xFF → the frame is still 0x55, and no second frame follows.
6. Reset asserted at E0+15 while 0xC3 is in flight:
   - Required: `tx=1` immediately, `tx_busy=0`, no `tx_done`.
   - A subsequent request with 0x0F produces a complete, correct 40-cycle frame.
